// File: rtl/rst_master_pkg.sv
// Shared definitions for the Avalon-MM reset pulse master.
//   state_e : sequencer states
//   HOLD_W  : width of the hold-length counter
//   TO_W    : width of the stall timeout counter
package rst_master_pkg;

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned TO_W   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrAssert,
    StHold,
    StWrRelease,
    StRdReq,
    StRdWait
  } state_e;

endpackage

// File: rtl/avmm_wait_timer.sv
// Loadable down-counter used both for the reset hold time and for the bus stall timeout.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : load value_i into the counter (has priority over en_i)
//   value_i      : load value
//   en_i         : decrement by one (saturates at zero)
//   expired_o    : counter currently holds 1, i.e. this enabled cycle is the last one
module avmm_wait_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign expired_o = (count_q == Width'(1));

endmodule

// File: rtl/avmm_rst_pulse_master.sv
// Avalon-MM initiator that pulses a single-bit PIO reset register: on start it writes
// ASSERT_VAL, waits hold_cycles_i idle cycles, then writes DEASSERT_VAL.
// Optional readback of the released value is enabled by defining RST_MASTER_READBACK_EN.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start_i           : one-cycle request to run a pulse sequence (ignored while busy)
//   hold_cycles_i     : idle cycles between the two writes, sampled at start (0 acts as 1)
//   busy_o, done_o    : sequence in progress / one-cycle success pulse
//   error_o           : sticky timeout or readback mismatch, cleared by the next start
//   m_*               : Avalon-MM master port (all outputs registered)
module avmm_rst_pulse_master
  import rst_master_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 2,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       TARGET_ADDR  = 0,
  parameter logic [DATA_W-1:0] ASSERT_VAL   = DATA_W'(1),
  parameter logic [DATA_W-1:0] DEASSERT_VAL = '0,
  parameter int unsigned       TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] m_address_o,
  output logic              m_write_o,
  output logic              m_read_o,
  output logic [DATA_W-1:0] m_writedata_o,
  input  logic [DATA_W-1:0] m_readdata_i,
  input  logic              m_waitrequest_i,
  input  logic              m_readdatavalid_i
);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              m_write_q, m_write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              hold_load, hold_en, hold_exp;
  logic [HOLD_W-1:0] hold_val;
  logic              wait_load, wait_en, wait_exp, timeout;

`ifdef RST_MASTER_READBACK_EN
  logic m_read_q, m_read_d;
  logic unused_rdata;
  assign unused_rdata = ^m_readdata_i[DATA_W-1:1];
`else
  logic unused_rd;
  assign unused_rd = ^{m_readdata_i, m_readdatavalid_i};
`endif

  // Hold timer: HOLD lasts exactly hold_q cycles with the bus idle.
  avmm_wait_timer #(
    .Width (HOLD_W)
  ) u_hold_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (hold_load),
    .value_i   (hold_val),
    .en_i      (hold_en),
    .expired_o (hold_exp)
  );

  // Stall timer: reloaded on every state change, counts consecutive stalled cycles.
  avmm_wait_timer #(
    .Width (TO_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (wait_load),
    .value_i   (TO_W'(TIMEOUT)),
    .en_i      (wait_en),
    .expired_o (wait_exp)
  );

  assign hold_en   = (state_q == StHold);
  assign wait_load = (state_d != state_q);
  assign timeout   = wait_en & wait_exp;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    m_write_d = m_write_q;
    wdata_d   = wdata_q;
    hold_load = 1'b0;
    hold_val  = hold_q;
    wait_en   = 1'b0;
`ifdef RST_MASTER_READBACK_EN
    m_read_d  = m_read_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          hold_d    = (hold_cycles_i == '0) ? HOLD_W'(1) : hold_cycles_i;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          m_write_d = 1'b1;
          wdata_d   = ASSERT_VAL;
          state_d   = StWrAssert;
        end
      end

      StWrAssert: begin
        wait_en = m_waitrequest_i;
        if (!m_waitrequest_i) begin
          m_write_d = 1'b0;
          hold_load = 1'b1;
          state_d   = StHold;
        end else if (timeout) begin
          // Abort: drop the write for one idle cycle, then attempt the release anyway.
          m_write_d = 1'b0;
          error_d   = 1'b1;
          hold_load = 1'b1;
          hold_val  = HOLD_W'(1);
          state_d   = StHold;
        end
      end

      StHold: begin
        if (hold_exp) begin
          m_write_d = 1'b1;
          wdata_d   = DEASSERT_VAL;
          state_d   = StWrRelease;
        end
      end

      StWrRelease: begin
        wait_en = m_waitrequest_i;
        if (!m_waitrequest_i) begin
          m_write_d = 1'b0;
          if (error_q) begin
            // Best-effort release after an abort: finish quietly, no done.
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
`ifdef RST_MASTER_READBACK_EN
            m_read_d = 1'b1;
            state_d  = StRdReq;
`else
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = StIdle;
`endif
          end
        end else if (timeout) begin
          m_write_d = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end

`ifdef RST_MASTER_READBACK_EN
      StRdReq: begin
        wait_en = m_waitrequest_i;
        if (!m_waitrequest_i) begin
          m_read_d = 1'b0;
          state_d  = StRdWait;
        end else if (timeout) begin
          m_read_d = 1'b0;
          error_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end

      StRdWait: begin
        wait_en = ~m_readdatavalid_i;
        if (m_readdatavalid_i) begin
          busy_d  = 1'b0;
          state_d = StIdle;
          if (m_readdata_i[0] != DEASSERT_VAL[0]) begin
            error_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
`endif

      default: begin
        busy_d    = 1'b0;
        m_write_d = 1'b0;
`ifdef RST_MASTER_READBACK_EN
        m_read_d  = 1'b0;
`endif
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hold_q    <= HOLD_W'(1);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      m_write_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      m_write_q <= m_write_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef RST_MASTER_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_read_q <= 1'b0;
    end else begin
      m_read_q <= m_read_d;
    end
  end
  assign m_read_o = m_read_q;
`else
  assign m_read_o = 1'b0;
`endif

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign m_write_o     = m_write_q;
  assign m_writedata_o = wdata_q;
  assign m_address_o   = ADDR_W'(TARGET_ADDR);

endmodule

// File: tb/tb_avmm_rst_pulse_master.sv
// Directed bench for avmm_rst_pulse_master. Inputs change 1 time unit after the rising edge
// and outputs are sampled at the same point, so each tick() moves exactly one cycle.
module tb_avmm_rst_pulse_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] hold_cycles_i = '0;
  logic        busy_o, done_o, error_o;
  logic [1:0]  m_address_o;
  logic        m_write_o, m_read_o;
  logic [31:0] m_writedata_o;
  logic [31:0] m_readdata_i = '0;
  logic        m_waitrequest_i = 1'b0;
  logic        m_readdatavalid_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int wr_accepts = 0;
  int done_count = 0;

  avmm_rst_pulse_master u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_i           (start_i),
    .hold_cycles_i     (hold_cycles_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .m_address_o       (m_address_o),
    .m_write_o         (m_write_o),
    .m_read_o          (m_read_o),
    .m_writedata_o     (m_writedata_o),
    .m_readdata_i      (m_readdata_i),
    .m_waitrequest_i   (m_waitrequest_i),
    .m_readdatavalid_i (m_readdatavalid_i)
  );

  always #5 clk = ~clk;

  // Bus-side observers: accepted writes and done pulses.
  always @(posedge clk) begin
    if (m_write_o && !m_waitrequest_i) wr_accepts <= wr_accepts + 1;
    if (done_o) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [15:0] h);
    hold_cycles_i = h;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Counts idle bus cycles until the next write is driven; optionally pokes start once.
  task automatic wait_gap(input bit poke, output int gap);
    gap = 0;
    while (!m_write_o && gap < 1000) begin
      if (poke && gap == 0) start_i = 1'b1;
      tick();
      start_i = 1'b0;
      gap++;
    end
  endtask

  // Current cycle drives the release write with waitrequest low; returns on the done cycle.
  task automatic complete_release(input logic rd_bit);
    tick();
`ifdef RST_MASTER_READBACK_EN
    checks++;
    if (m_read_o !== 1'b1) begin
      errors++; $display("FAIL rd_req: m_read got %b expected 1", m_read_o);
    end
    tick();
    m_readdata_i = {31'b0, rd_bit};
    m_readdatavalid_i = 1'b1;
    tick();
    m_readdatavalid_i = 1'b0;
    m_readdata_i = '0;
`endif
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy_o, done_o, error_o, m_write_o, m_read_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {busy_o, done_o, error_o, m_write_o, m_read_o});
    end
    checks++;
    if (m_writedata_o !== 32'h0 || m_address_o !== 2'd0) begin
      errors++; $display("FAIL reset_bus: data %h addr %h expected 0 0", m_writedata_o, m_address_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int gap;
    int wr_base = wr_accepts;
    int dn_base = done_count;
    m_waitrequest_i = 1'b0;
    start_seq(16'd4);
    checks++;
    if ({busy_o, m_write_o} !== 2'b11 || m_writedata_o !== 32'd1) begin
      errors++; $display("FAIL basic_assert: busy/write %b data %h expected 11 1",
                         {busy_o, m_write_o}, m_writedata_o);
    end
    tick();
    wait_gap(1'b0, gap);
    checks++;
    if (gap !== 4) begin
      errors++; $display("FAIL basic_gap: got %0d expected 4", gap);
    end
    checks++;
    if (m_write_o !== 1'b1 || m_writedata_o !== 32'd0) begin
      errors++; $display("FAIL basic_release: write %b data %h expected 1 0", m_write_o, m_writedata_o);
    end
    complete_release(1'b0);
    checks++;
    if ({done_o, busy_o, m_write_o, m_read_o, error_o} !== 5'b10000) begin
      errors++; $display("FAIL basic_done: got %b expected 10000",
                         {done_o, busy_o, m_write_o, m_read_o, error_o});
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || done_count - dn_base !== 1 || wr_accepts - wr_base !== 2) begin
      errors++; $display("FAIL basic_counts: done %b pulses %0d writes %0d expected 0 1 2",
                         done_o, done_count - dn_base, wr_accepts - wr_base);
    end
  endtask

  task automatic test_stall();
    int gap;
    int wr_base = wr_accepts;
    m_waitrequest_i = 1'b1;
    start_seq(16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_write_o !== 1'b1 || m_writedata_o !== 32'd1) begin
        errors++; $display("FAIL stall_assert_%0d: write %b data %h expected 1 1",
                           i, m_write_o, m_writedata_o);
      end
      tick();
    end
    m_waitrequest_i = 1'b0;
    tick();
    wait_gap(1'b0, gap);
    checks++;
    if (gap !== 3) begin
      errors++; $display("FAIL stall_gap: got %0d expected 3", gap);
    end
    m_waitrequest_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_write_o !== 1'b1 || m_writedata_o !== 32'd0) begin
        errors++; $display("FAIL stall_release_%0d: write %b data %h expected 1 0",
                           i, m_write_o, m_writedata_o);
      end
      tick();
    end
    m_waitrequest_i = 1'b0;
    complete_release(1'b0);
    checks++;
    if ({done_o, error_o, wr_accepts - wr_base} !== {2'b10, 32'd2}) begin
      errors++; $display("FAIL stall_done: done %b error %b writes %0d expected 1 0 2",
                         done_o, error_o, wr_accepts - wr_base);
    end
    tick();
  endtask

  task automatic test_hold_zero();
    int gap;
    int wr_base = wr_accepts;
    m_waitrequest_i = 1'b0;
    start_seq(16'd0);
    tick();
    wait_gap(1'b1, gap);
    checks++;
    if (gap !== 1) begin
      errors++; $display("FAIL hold0_gap: got %0d expected 1", gap);
    end
    complete_release(1'b0);
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("FAIL hold0_done: got %b expected 1", done_o);
    end
    repeat (3) tick();
    checks++;
    if ({busy_o, m_write_o} !== 2'b00 || wr_accepts - wr_base !== 2) begin
      errors++; $display("FAIL hold0_noqueue: busy/write %b writes %0d expected 00 2",
                         {busy_o, m_write_o}, wr_accepts - wr_base);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int gap;
    int dn_base = done_count;
    m_waitrequest_i = 1'b1;
    start_seq(16'd2);
    while (m_write_o && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 255) begin
      errors++; $display("FAIL to_stall_len: got %0d expected 255", n);
    end
    checks++;
    if ({error_o, m_write_o, done_o} !== 3'b100) begin
      errors++; $display("FAIL to_abort: error/write/done %b expected 100",
                         {error_o, m_write_o, done_o});
    end
    m_waitrequest_i = 1'b0;
    tick();
    checks++;
    if (m_write_o !== 1'b1 || m_writedata_o !== 32'd0) begin
      errors++; $display("FAIL to_release: write %b data %h expected 1 0", m_write_o, m_writedata_o);
    end
    tick();
    checks++;
    if ({busy_o, done_o, error_o, m_write_o, m_read_o} !== 5'b00100 || done_count !== dn_base) begin
      errors++; $display("FAIL to_end: flags %b pulses %0d expected 00100 0",
                         {busy_o, done_o, error_o, m_write_o, m_read_o}, done_count - dn_base);
    end
    start_seq(16'd2);
    checks++;
    if ({error_o, busy_o} !== 2'b01) begin
      errors++; $display("FAIL to_clear: error/busy %b expected 01", {error_o, busy_o});
    end
    tick();
    wait_gap(1'b0, gap);
    complete_release(1'b0);
    checks++;
    if ({done_o, error_o} !== 2'b10) begin
      errors++; $display("FAIL to_recover: done/error %b expected 10", {done_o, error_o});
    end
    tick();
  endtask

`ifdef RST_MASTER_READBACK_EN
  task automatic test_readback();
    int gap;
    m_waitrequest_i = 1'b0;
    start_seq(16'd2);
    tick();
    wait_gap(1'b0, gap);
    complete_release(1'b1);
    checks++;
    if ({done_o, error_o, busy_o} !== 3'b010) begin
      errors++; $display("FAIL rb_mismatch: done/error/busy %b expected 010",
                         {done_o, error_o, busy_o});
    end
    tick();
    start_seq(16'd2);
    tick();
    wait_gap(1'b0, gap);
    complete_release(1'b0);
    checks++;
    if ({done_o, error_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL rb_match: done/error/busy %b expected 100",
                         {done_o, error_o, busy_o});
    end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    int highs = 0;
    int wr_base;
    m_waitrequest_i = 1'b0;
    start_seq(16'd10);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, error_o, m_write_o, m_read_o} !== 5'b0 || m_writedata_o !== 32'h0) begin
      errors++; $display("FAIL areset_outputs: flags %b data %h expected 00000 0",
                         {busy_o, done_o, error_o, m_write_o, m_read_o}, m_writedata_o);
    end
    tick();
    reset_n = 1'b1;
    wr_base = wr_accepts;
    for (int i = 0; i < 20; i++) begin
      if (m_write_o || m_read_o || busy_o) highs++;
      tick();
    end
    checks++;
    if (highs !== 0 || wr_accepts - wr_base !== 0) begin
      errors++; $display("FAIL areset_quiet: active cycles %0d writes %0d expected 0 0",
                         highs, wr_accepts - wr_base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hold_zero();
    test_timeout();
`ifdef RST_MASTER_READBACK_EN
    test_readback();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d checks %0d", errors, checks);
    $fatal(1);
  end

endmodule
